// File: rtl/y86_instr_serializer_pkg.sv
// Shared Y86-64 definitions: icode constants, field-presence decode and the
// instruction-memory address limit. Used by both fetch and the serializer.
package y86_instr_serializer_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [63:0] IMEM_LIMIT = 64'd1024;

    function automatic logic need_regids(input logic [3:0] icode);
        return icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        return icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    endfunction

endpackage

// File: rtl/y86_instr_serializer_len.sv
// Combinational instruction-length decode: which optional fields an icode
// carries, the resulting byte count (1, 2, 9 or 10) and icode validity.
module y86_instr_len
    import y86_instr_serializer_pkg::*;
(
    input  logic [3:0] icode,
    output logic       need_regids_o,
    output logic       need_valc_o,
    output logic [3:0] len_o,
    output logic       icode_ok_o
);

    always_comb begin
        need_regids_o = need_regids(icode);
        need_valc_o   = need_valc(icode);
        icode_ok_o    = (icode <= IPOPQ);
        len_o         = 4'd1 + {3'd0, need_regids_o} + (need_valc_o ? 4'd8 : 4'd0);
    end

endmodule

// File: rtl/y86_instr_serializer.sv
// Serializes Y86-64 instruction fields into a byte stream with contiguous
// memory addresses; the inverse of the fetch-side split/align.
module y86_instr_serializer
    import y86_instr_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_base,
    input  logic [63:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [3:0]  in_ifun,
    input  logic [3:0]  in_rA,
    input  logic [3:0]  in_rB,
    input  logic [63:0] in_valC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_addr,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        err_icode,
    output logic        err_addr
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  len_q, len_d;
    logic        err_icode_q, err_icode_d;
    logic        err_addr_q, err_addr_d;
    logic [79:0] shreg_q, shreg_d;

    logic       dec_regids, dec_valc, dec_ok;
    logic [3:0] dec_len;
    logic       addr_over, out_fire, last_fire, in_fire;

    y86_instr_len u_len (
        .icode         (in_icode),
        .need_regids_o (dec_regids),
        .need_valc_o   (dec_valc),
        .len_o         (dec_len),
        .icode_ok_o    (dec_ok)
    );

    // A byte whose address lies past the limit is never presented.
    assign addr_over = (addr_q > IMEM_LIMIT);
    assign out_valid = (state_q == S_EMIT) && !addr_over;
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && (idx_q == len_q - 4'd1);
    assign in_ready  = !ld_base && ((state_q == S_IDLE) || last_fire);
    assign in_fire   = in_valid && in_ready;

    assign out_addr  = addr_q;
    assign out_data  = out_valid ? shreg_q[79:72] : 8'h00;
    assign busy      = (state_q != S_IDLE);
    assign err_icode = err_icode_q;
    assign err_addr  = err_addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        len_d       = len_q;
        shreg_d     = shreg_q;
        err_icode_d = err_icode_q;
        err_addr_d  = err_addr_q;

        if (state_q == S_IDLE) begin
            if (ld_base) addr_d = base_addr;
        end else if (addr_over) begin
            err_addr_d = 1'b1;
            state_d    = S_IDLE;
        end else if (out_fire) begin
            addr_d  = addr_q + 64'd1;
            idx_d   = idx_q + 4'd1;
            shreg_d = {shreg_q[71:0], 8'h00};
            if (last_fire) state_d = S_IDLE;
        end

        // Bytes are left-justified in the shift register, valC MSB first.
        if (in_fire) begin
            if (dec_ok) begin
                state_d = S_EMIT;
                idx_d   = 4'd0;
                len_d   = dec_len;
                shreg_d = dec_regids ? {in_icode, in_ifun, in_rA, in_rB, in_valC}
                                     : {in_icode, in_ifun, in_valC, 8'h00};
            end else begin
                err_icode_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 64'd0;
            idx_q       <= 4'd0;
            len_q       <= 4'd0;
            err_icode_q <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            err_icode_q <= err_icode_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_y86_instr_serializer.sv
// Bench for y86_instr_serializer: directed scenarios plus a randomized run,
// all scored against a byte-list reference model.
module tb_y86_instr_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_base = 1'b0;
    logic [63:0] base_addr = 64'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_icode = 4'd0, in_ifun = 4'd0, in_rA = 4'd0, in_rB = 4'd0;
    logic [63:0] in_valC = 64'd0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_addr;
    logic [7:0]  out_data;
    logic        busy, err_icode, err_addr;

    y86_instr_serializer dut (
        .clk(clk), .rst_n(rst_n), .ld_base(ld_base), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode),
        .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .err_icode(err_icode), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the expected (address, byte) stream per instruction.
    typedef struct packed { logic [63:0] a; logic [7:0] d; } byte_t;
    byte_t       exp_q[$];
    byte_t       log_q[$];
    int          log_cyc[$];
    byte_t       e;
    logic [63:0] m_addr = 64'd0;
    logic        m_err_icode = 1'b0, m_err_addr = 1'b0;

    function automatic void model_accept(input logic [3:0] ic, input logic [3:0] ifn,
                                         input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [63:0] vc);
        logic [7:0] b[$];
        if (ic > 4'hB) begin
            m_err_icode = 1'b1;
            return;
        end
        b.push_back({ic, ifn});
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) b.push_back({ra, rb});
        if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
            for (int k = 7; k >= 0; k--) b.push_back(vc[8*k +: 8]);
        for (int i = 0; i < b.size(); i++) begin
            if (m_addr > 64'd1024) begin
                m_err_addr = 1'b1;
                break;
            end
            exp_q.push_back({m_addr, b[i]});
            m_addr = m_addr + 64'd1;
        end
    endfunction

    bit          chk_busy = 1'b1;
    bit          stalled = 1'b0;
    logic [63:0] st_addr;
    logic [7:0]  st_data;

    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_busy) check("busy", busy, {63'd0, exp_q.size() != 0});
            check("err_icode", err_icode, m_err_icode);
            if (ld_base) begin
                check("rdy_during_ld", in_ready, 0);
                if (exp_q.size() == 0) m_addr = base_addr;
            end
            if (stalled) begin
                check("stall_vld", out_valid, 1);
                check("stall_addr", out_addr, st_addr);
                check("stall_data", out_data, st_data);
            end
            stalled = out_valid && !out_ready;
            st_addr = out_addr;
            st_data = out_data;
            if (out_valid && exp_q.size() == 0) begin
                check("spurious_byte", out_valid, 0);
            end else if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("out_addr", out_addr, e.a);
                check("out_data", out_data, e.d);
                log_q.push_back({out_addr, out_data});
                log_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) model_accept(in_icode, in_ifun, in_rA, in_rB, in_valC);
        end else begin
            stalled = 1'b0;
        end
    end

    int rdy_mode = 0, rdy_cnt = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (rdy_cnt % 3 == 0); rdy_cnt++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc);
        int t = 0;
        in_icode = ic; in_ifun = ifn; in_rA = ra; in_rB = rb; in_valC = vc;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 300) begin @(negedge clk); t++; end
        if (!in_ready) check("send_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [63:0] a);
        ld_base = 1'b1; base_addr = a;
        @(posedge clk); #1;
        ld_base = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 400) begin @(posedge clk); #1; t++; end
        if (t >= 400) check("drain_timeout", 1, 0);
    endtask

    logic [7:0] s1_bytes[10] = '{8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23};
    logic [7:0] s2_bytes[4]  = '{8'h00, 8'h90, 8'h60, 8'h01};
    logic [7:0] s5_bytes[5]  = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int t;
        logic [3:0] ic;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_err_icode", err_icode, 0);
        check("rst_err_addr", err_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // irmovq at 0x10 with a ready sink
        load(64'h10);
        log_q.delete(); log_cyc.delete();
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h123);
        in_valid = 1'b0;
        @(negedge clk);
        check("s1_latency_vld", out_valid, 1);
        check("s1_latency_data", out_data, 8'h30);
        check("s1_latency_addr", out_addr, 64'h10);
        @(posedge clk); #1;
        drain();
        check("s1_busy_fall_cyc", cyc, log_cyc.size() > 0 ? log_cyc[log_cyc.size()-1] + 1 : -1);
        check("s1_count", log_q.size(), 10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            check("s1_data", log_q[i].d, s1_bytes[i]);
            check("s1_addr", log_q[i].a, 64'h10 + i);
        end

        // halt, ret, addq back to back
        log_q.delete(); log_cyc.delete();
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
        send(4'h9, 4'h0, 4'h0, 4'h0, 64'd0);
        send(4'h6, 4'h0, 4'h0, 4'h1, 64'd0);
        in_valid = 1'b0;
        drain();
        check("s2_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("s2_data", log_q[i].d, s2_bytes[i]);
            check("s2_addr", log_q[i].a, 64'h1A + i);
            check("s2_no_gap", log_cyc[i], log_cyc[0] + i);
        end

        // jmp with a stalling sink
        log_q.delete(); log_cyc.delete();
        rdy_cnt = 0; rdy_mode = 1;
        send(4'h7, 4'h0, 4'hF, 4'hF, 64'h40);
        in_valid = 1'b0;
        drain();
        rdy_mode = 0;
        check("s3_count", log_q.size(), 9);
        if (log_q.size() == 9) begin
            check("s3_first", log_q[0].d, 8'h70);
            check("s3_last", log_q[8].d, 8'h40);
            check("s3_last_addr", log_q[8].a, 64'h1E + 8);
        end

        // invalid icode, then a normal nop
        log_q.delete(); log_cyc.delete();
        send(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("s4_no_bytes", log_q.size(), 0);
        check("s4_err_icode", err_icode, 1);
        check("s4_busy", busy, 0);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
        in_valid = 1'b0;
        drain();
        check("s4_nop_count", log_q.size(), 1);
        if (log_q.size() == 1) check("s4_nop_data", log_q[0].d, 8'h10);
        check("s4_err_icode_held", err_icode, 1);

        // call crossing the address limit
        chk_busy = 1'b0;
        load(64'd1020);
        log_q.delete(); log_cyc.delete();
        send(4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788);
        in_valid = 1'b0;
        drain();
        repeat (3) begin @(posedge clk); #1; end
        check("s5_count", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            check("s5_data", log_q[i].d, s5_bytes[i]);
            check("s5_addr", log_q[i].a, 64'd1020 + i);
        end
        check("s5_err_addr", err_addr, 1);
        check("s5_busy", busy, 0);
        check("s5_out_valid", out_valid, 0);

        // reset during byte 4 of rmmovq
        load(64'h100);
        chk_busy = 1'b1;
        log_q.delete(); log_cyc.delete();
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'hAABBCCDDEEFF0011);
        in_valid = 1'b0;
        t = 0;
        while (log_q.size() < 3 && t < 50) begin @(negedge clk); #1; t++; end
        check("s6_reached_byte4", log_q.size(), 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete(); m_addr = 64'd0; m_err_icode = 1'b0; m_err_addr = 1'b0;
        #1;
        check("s6_out_valid", out_valid, 0);
        check("s6_busy", busy, 0);
        check("s6_out_data", out_data, 0);
        check("s6_out_addr", out_addr, 0);
        check("s6_err_icode", err_icode, 0);
        check("s6_err_addr", err_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        check("s6_no_residual", log_q.size(), 3);

        // randomized traffic with a random sink and stray ld_base pulses
        rdy_mode = 2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) load(64'($urandom_range(0, 400)));
            ic = 4'($urandom_range(0, 13));
            send(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        end
        in_valid = 1'b0;
        drain();
        rdy_mode = 0;
        check("rnd_pending", exp_q.size(), 0);
        check("rnd_err_addr", err_addr, 0);
        check("rnd_err_icode", err_icode, m_err_icode);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
